// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, fault codes and
// fixed words used by the instruction fetch unit and its helpers.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_MISS     = 2'b11;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_miss_counter.sv
// Saturating count of consecutive fetch misses; limit_next flags that one more
// increment would reach LIMIT.
module fetch_miss_counter #(
  parameter int unsigned LIMIT = 8,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_next
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != W'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_next = (count_q >= W'(LIMIT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches from a combinational instruction memory
// and loads the IF/ID register, handling stalls, redirects, misses and faults.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64,
  parameter int unsigned MISS_LIMIT = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  output logic [31:0]  IAddr,
  input  logic [31:0]  IData,
  input  logic         IMemError,
  input  logic         Stall,
  input  logic         RedirectEn,
  input  logic [31:0]  RedirectPC,
  output logic [31:0]  InstrOut,
  output logic [31:0]  PCPlus4Out,
  output logic         ValidOut,
  output logic         FetchFault,
  output logic [1:0]   FaultCode,
  output fetch_state_e dbg_state
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [1:0]   code_q, code_d;
  fetch_state_e state_q, state_d;
  logic         miss_clr, miss_inc, miss_limit_next;

  fetch_miss_counter #(.LIMIT(MISS_LIMIT)) u_miss_counter (
    .clk        (Clk),
    .rst        (Rst),
    .clr        (miss_clr),
    .inc        (miss_inc),
    .limit_next (miss_limit_next)
  );

  // Priority below the FAULT freeze: redirect, range, stall, miss, fetch.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    code_d   = code_q;
    state_d  = state_q;
    miss_clr = 1'b0;
    miss_inc = 1'b0;
    if (state_q != ST_FAULT) begin
      if (RedirectEn) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        if (RedirectPC[1:0] != 2'b00) begin
          state_d = ST_FAULT;
          code_d  = FC_MISALIGN;
        end else begin
          pc_d     = RedirectPC;
          miss_clr = 1'b1;
          state_d  = ST_RUN;
        end
      end else if (pc_q > PC_MAX) begin
        valid_d = 1'b0;
        state_d = ST_FAULT;
        code_d  = FC_RANGE;
      end else if (Stall) begin
        miss_inc = IMemError;
      end else if (IMemError) begin
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
        miss_inc = 1'b1;
        if (miss_limit_next) begin
          state_d = ST_FAULT;
          code_d  = FC_MISS;
        end else begin
          state_d = ST_MISS;
        end
      end else begin
        instr_d  = IData;
        pc4_d    = pc_q + PC_INC;
        valid_d  = 1'b1;
        pc_d     = pc_q + PC_INC;
        miss_clr = 1'b1;
        state_d  = ST_RUN;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= FC_NONE;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      state_q <= state_d;
    end
  end

  assign IAddr      = pc_q;
  assign InstrOut   = instr_q;
  assign PCPlus4Out = pc4_q;
  assign ValidOut   = valid_q;
  assign FaultCode  = code_q;
  assign FetchFault = (state_q == ST_FAULT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan steps followed by a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_instruction_fetch_unit;
  import mips_fetch_pkg::*;

  localparam int MEM_WORDS = 16;
  localparam int LIMIT     = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [31:0]  IAddr;
  logic [31:0]  IData;
  logic         IMemError = 1'b0;
  logic         Stall = 1'b0;
  logic         RedirectEn = 1'b0;
  logic [31:0]  RedirectPC = '0;
  logic [31:0]  InstrOut;
  logic [31:0]  PCPlus4Out;
  logic         ValidOut;
  logic         FetchFault;
  logic [1:0]   FaultCode;
  fetch_state_e dbg_state;

  logic [31:0] mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  // Reference model: the architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault;
  logic [1:0]  m_code;
  int          m_misses;

  instruction_fetch_unit dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .IAddr      (IAddr),
    .IData      (IData),
    .IMemError  (IMemError),
    .Stall      (Stall),
    .RedirectEn (RedirectEn),
    .RedirectPC (RedirectPC),
    .InstrOut   (InstrOut),
    .PCPlus4Out (PCPlus4Out),
    .ValidOut   (ValidOut),
    .FetchFault (FetchFault),
    .FaultCode  (FaultCode),
    .dbg_state  (dbg_state)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    IData = 32'hDEAD_BEEF;
    if (IAddr < 32'(MEM_WORDS * 4)) IData = mem[IAddr[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic stall, input logic err,
                            input logic redir, input logic [31:0] rpc);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fault = 1'b0; m_code = 2'b00; m_misses = 0;
    end else if (m_fault) begin
      // frozen until reset
    end else if (redir) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (rpc % 4 != 0) begin
        m_fault = 1'b1; m_code = 2'b01;
      end else begin
        m_pc = rpc; m_misses = 0;
      end
    end else if (m_pc > 32'(MEM_WORDS * 4 - 4)) begin
      m_fault = 1'b1; m_code = 2'b10; m_valid = 1'b0;
    end else if (stall) begin
      if (err && m_misses < LIMIT) m_misses++;
    end else if (err) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (m_misses + 1 >= LIMIT) begin
        m_fault = 1'b1; m_code = 2'b11;
      end else begin
        m_misses++;
      end
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_misses = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".iaddr"}, IAddr, m_pc);
    chk({tag, ".instr"}, InstrOut, m_instr);
    chk({tag, ".valid"}, 32'(ValidOut), 32'(m_valid));
    chk({tag, ".fault"}, 32'(FetchFault), 32'(m_fault));
    chk({tag, ".code"}, 32'(FaultCode), 32'(m_code));
    if (m_valid) chk({tag, ".pc4"}, PCPlus4Out, m_pc4);
  endtask

  task automatic step(input string tag, input logic rst, input logic stall,
                      input logic err, input logic redir, input logic [31:0] rpc);
    Rst = rst; Stall = stall; IMemError = err; RedirectEn = redir; RedirectPC = rpc;
    @(posedge Clk);
    model_edge(rst, stall, err, redir, rpc);
    #1;
    compare_all(tag);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;

    // Reset
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_pc4", PCPlus4Out, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(ST_RUN));

    // Sequential fetch and stall at PC=8
    step("fetch0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fetch0_word", InstrOut, mem[0]);
    step("fetch1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fetch1_pc4", PCPlus4Out, 32'd8);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_iaddr", IAddr, 32'd8);
    chk("stall_hold", InstrOut, mem[1]);
    step("fetch2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("after_stall_word", InstrOut, mem[2]);

    // Redirect with stall at PC=0x0C, then misaligned redirect
    step("redir", 1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    chk("redir_iaddr", IAddr, 32'h20);
    chk("redir_bubble", 32'(ValidOut), 32'd0);
    step("redir_tgt", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_tgt_word", InstrOut, mem[8]);
    step("misalign", 1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
    chk("misalign_code", 32'(FaultCode), 32'h1);
    chk("misalign_pc", IAddr, 32'h24);

    // Miss retry at PC=0x10, then miss-limit fault
    step("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step("pre_miss", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step("miss3", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("miss3_iaddr", IAddr, 32'h10);
    step("miss_resume", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("miss_resume_word", InstrOut, mem[4]);
    for (int i = 0; i < 7; i++) step("miss8", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("miss7_nofault", 32'(FetchFault), 32'd0);
    step("miss8_last", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("miss8_code", 32'(FaultCode), 32'h3);
    step("fault_redir", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("fault_redir_ignored", IAddr, 32'h14);

    // Run past the end of memory, then reset
    step("rst3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < MEM_WORDS; i++) step("seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq_end_pc", IAddr, 32'h40);
    step("range", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("range_code", 32'(FaultCode), 32'h2);
    chk("range_valid", 32'(ValidOut), 32'd0);
    step("rst4", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst4_pc4", PCPlus4Out, 32'h0);
    chk("rst4_instr", InstrOut, 32'h0);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic r_rst, r_stall, r_err, r_redir;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 99) < 2) || (m_fault && $urandom_range(0, 9) == 0);
      r_stall = ($urandom_range(0, 99) < 20);
      r_err   = ($urandom_range(0, 99) < 25);
      r_redir = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 9))
        0:       r_pc = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        1:       r_pc = 32'h40 + 32'($urandom_range(0, 15) * 4);
        default: r_pc = 32'($urandom_range(0, 15) * 4);
      endcase
      step("rand", r_rst, r_stall, r_err, r_redir, r_pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-side initiator for the byte-addressed, combinational-read instruction memory. Holds the program counter, drives the fetch address, samples the returned 32-bit word and loads the IF/ID pipeline register. It sits between the instruction memory and the decode stage and handles downstream stalls, branch/jump redirects, memory miss (`IMemError`) retry and fetch faults.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_BYTES`, default 64: instruction memory size in bytes; the legal PC range is 0 .. IMEM_BYTES-4.
- `MISS_LIMIT`, default 8: number of consecutive miss cycles that causes a fault.

Ports:
- `Clk`, in, 1: single clock; all state updates on the rising edge.
- `Rst`, in, 1: reset, synchronous, active-high.
- `IAddr`, out, 32: fetch address, equal to the PC register.
- `IData`, in, 32: instruction word returned combinationally for `IAddr`.
- `IMemError`, in, 1: memory miss for the current `IAddr`; `IData` is invalid.
- `Stall`, in, 1: decode stage cannot accept; hold IF/ID.
- `RedirectEn`, in, 1: taken branch or jump this cycle.
- `RedirectPC`, in, 32: redirect target.
- `InstrOut`, out, 32: IF/ID instruction.
- `PCPlus4Out`, out, 32: IF/ID PC+4 of `InstrOut`.
- `ValidOut`, out, 1: `InstrOut` is a real instruction (0 = bubble/NOP).
- `FetchFault`, out, 1: sticky fault flag.
- `FaultCode`, out, 2: 00 none, 01 misaligned redirect, 10 PC out of range, 11 miss limit reached.

## Operation
- States: RUN, MISS, FAULT.
- Reset: PC=RESET_PC, state RUN, InstrOut=0, PCPlus4Out=0, ValidOut=0, FetchFault=0, FaultCode=00, miss counter=0.
- Per-edge priority: Rst > FAULT > RedirectEn > range check > Stall > IMemError > normal fetch.
- FAULT: PC and IF/ID are frozen, ValidOut=0, and RedirectEn is ignored. Only Rst exits this state.
- RedirectEn, in RUN or MISS:
  - If RedirectPC[1:0] != 0, go to FAULT with code 01. The PC is not updated and IF/ID is flushed.
  - Otherwise PC=RedirectPC, IF/ID is flushed (InstrOut=0, ValidOut=0), miss counter=0, state RUN.
  - Redirect overrides Stall.
- Range check: in RUN or MISS with no redirect, if PC > IMEM_BYTES-4, go to FAULT with code 10. No fetch is recorded.
- Stall, with no redirect: PC, IF/ID and state are held. If IMemError is also high, the miss counter still increments.
- IMemError, with no stall and no redirect:
  - PC is held and a bubble is inserted (ValidOut=0).
  - State goes to MISS and the counter increments (saturating).
  - When the counter would reach MISS_LIMIT, go to FAULT with code 11.
- Normal fetch (RUN or MISS, IMemError=0, no stall, no redirect):
  - InstrOut=IData, PCPlus4Out=PC+4, ValidOut=1, PC=PC+4.
  - Miss counter=0, state RUN.
- Arithmetic: PC+4 is unsigned 32-bit and wraps modulo 2^32. Wrapped values are caught by the range check.

## Timing
- `IAddr` is a register output, so it is valid from the clock edge.
- `IData` and `IMemError` are sampled at the next rising edge.
- Latency: the instruction at PC appears on `InstrOut` one cycle after PC is presented.
- After a redirect edge there is one bubble. The target instruction is valid on the following edge, assuming no miss.
- Miss fault: with MISS_LIMIT=8 and IMemError held high, FAULT is entered at the 8th consecutive miss edge.
- Reset asserted mid-miss or mid-fault fully reinitialises the block on that edge.

## Structure
- The shared package `mips_fetch_pkg` holds:
  - the state enum (RUN/MISS/FAULT);
  - the FaultCode constants;
  - the NOP word 32'h0000_0000;
  - the PC increment constant 4.
- Sub-module `fetch_miss_counter`: saturating counter with clear, increment and limit-reached output, width $clog2(MISS_LIMIT+1).

## Test plan
- Reset, then IData = word(addr) with no errors: `InstrOut` sequence is words at 0,4,8,…; `PCPlus4Out` = 4,8,12; ValidOut=1 from cycle 1.
- Stall held for 3 cycles at PC=8: IAddr stays 8 and IF/ID is unchanged. After release, the instruction at 8 is latched next.
- RedirectEn with RedirectPC=0x20 at PC=0x0C, with Stall=1 in the same cycle: next IAddr=0x20 and ValidOut=0 for 1 cycle, then the word at 0x20 is valid. RedirectPC=0x22: FaultCode=01, PC unchanged.
- IMemError for 3 cycles at PC=0x10: ValidOut=0 for 3 cycles and IAddr holds at 0x10, then normal fetch resumes. IMemError held for 8 cycles: FetchFault=1 with code 11, and a later redirect is ignored.
- Sequential run past IMEM_BYTES=64: on PC=0x40, FetchFault=1 with code 10 and ValidOut=0. Rst asserted afterwards: PC=RESET_PC and all outputs return to their reset values.
